bin_avg_sequencer: RTL and testbench
====================================

Name: bin_avg_sequencer

Overview:
- Control sequencer for the N-bin averaging datapath that sits between the FFT output stream and the Ethernet packetizer.
- Tracks the bin index and the number of frames averaged so far.
- Drives the accumulator clear, accumulate and dump strobes, with the input data delayed to align with those strobes.
- Holds each finished average until the downstream packetizer accepts it, and counts FFT frames that arrive while the result is held.

Parameters:
- BINS, 4, number of bins per FFT frame; must be 2 or more.
- N, 16, input sample width.
- AVG_W, 8, width of the averages-count input.
- DROP_W, 16, width of the dropped-frame counter.
- HOLD_TIMEOUT, 1024, cycles allowed in HOLD. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- arest_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run control; sampled only in IDLE and at average boundaries.
- n_avgs_in  in  AVG_W  requested frames per average; 0 is treated as 1.
- fft_ready  in  1  one-cycle pulse marking bin 0 of a frame. Bins 0..BINS-1 arrive on in_data on consecutive cycles starting in the same cycle.
- in_data  in  N  FFT bin sample.
- out_ready  in  1  downstream packetizer accepts the held average.
- data_d  out  N  in_data delayed by 1 cycle, aligned to the strobes.
- bin_idx  out  $clog2(BINS)  bin index of data_d.
- acc_clear  out  1  load data_d into the accumulator instead of adding (first frame of an average).
- acc_en  out  1  accumulate data_d into slot bin_idx.
- dump  out  1  last bin of the last frame; the average completes next cycle.
- out_valid  out  1  average held and available.
- busy  out  1  state is not IDLE.
- overrun  out  1  one-cycle pulse: fft_ready arrived mid-frame.
- drop_cnt  out  DROP_W  saturating count of frames dropped in HOLD.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset acts immediately and aborts any frame in progress without asserting dump.
- All outputs are registered. Strobes trail the sample on in_data by exactly 1 cycle.
- The latched averages count n_lat is captured when leaving IDLE and after each dump, with 0 replaced by 1. A change to n_avgs_in mid-average has no effect until the next boundary.
- Frame counter fcnt runs 0..n_lat-1. Bin counter bcnt runs 0..BINS-1.

State machine:
- IDLE:
  - If enable is 1, latch n_lat and go to WAIT.
- WAIT:
  - fft_ready=1 starts ACCUM with bcnt=0 on that cycle's sample.
  - If enable has dropped at an average boundary (fcnt=0), return to IDLE.
- ACCUM:
  - Each cycle: acc_en=1 (delayed), and acc_clear=1 when fcnt=0.
  - When bcnt=BINS-1:
    - If fcnt=n_lat-1: dump=1, fcnt cleared, go to HOLD.
    - Otherwise: fcnt++, go to WAIT.
  - fft_ready=1 while bcnt≠0:
    - overrun pulse, fcnt forced to 0, and the current cycle's sample is treated as bin 0 of a new average (acc_clear=1).
    - The partial average is discarded and dump is not asserted.
- HOLD:
  - out_valid=1.
  - Exit on out_ready=1: go to WAIT if enable=1, otherwise IDLE. out_valid clears on the next cycle.
  - fft_ready=1 in HOLD: the frame is ignored (no strobes) and drop_cnt increments, saturating at all-ones.
  - fft_ready on the same cycle as out_ready: the frame is dropped and counted; the next frame is accepted.
- n_lat=1: every frame asserts both acc_clear and dump.
- Simultaneous fft_ready and the final bin cannot occur legally. If it does, it is treated as overrun.

Optional Feature:
- Macro: BIN_SEQ_HOLD_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in HOLD.
  - After HOLD_TIMEOUT cycles without out_ready, the held result is discarded: out_valid drops, drop_cnt increments, and the state goes to WAIT.
  - An extra output, timeout (1-cycle pulse), is present.
- Without the macro: HOLD waits indefinitely, and the timeout port and counter do not exist.

Test Plan:
1. Reset with enable=1, n_avgs_in=1, BINS=4, and four frames of samples from a fixed table (frame 1 = 5af7,9a7b,2392,dc44). Required response: each frame gives acc_en for 4 cycles with acc_clear=1, bin_idx 0..3 one cycle after each sample, data_d equal to the delayed samples, and dump on bin 3. With out_ready=1, out_valid pulses once per frame.
2. n_avgs_in=3 with 6 back-to-back frames. Required response: acc_clear only in frames 1 and 4, dump only in frames 3 and 6. Changing n_avgs_in to 2 during frame 2 has no effect until frame 4.
3. out_ready held 0 for 3 frames after dump. Required response: drop_cnt=3 and no strobes during those frames. Raising out_ready returns to WAIT and the next frame has acc_clear=1.
4. fft_ready pulsed again at bcnt=2. Required response: one overrun pulse, no dump, and the new frame starts with acc_clear=1 and bin_idx=0.
5. Assert arest_n=0 mid-ACCUM, at bin 1. Required response: all outputs 0 immediately and no dump. After release, n_avgs_in=0 behaves as n_lat=1.
6. With BIN_SEQ_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=8, hold out_ready=0. Required response: timeout pulse 8 cycles after out_valid rises, drop_cnt=1, and the state returns to WAIT.

Source files
------------

// File: rtl/bin_avg_sequencer_if.sv
// Stream-side bundle of the bin averaging sequencer: FFT sample input,
// accumulator strobes with aligned data, and the held-result handshake.
interface bin_avg_sequencer_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned BINS = 4
);
    localparam int unsigned BIN_W = $clog2(BINS);

    logic             fft_ready;
    logic [N-1:0]     in_data;
    logic             out_ready;
    logic [N-1:0]     data_d;
    logic [BIN_W-1:0] bin_idx;
    logic             acc_clear;
    logic             acc_en;
    logic             dump;
    logic             out_valid;

    modport slave (
        input  fft_ready, in_data, out_ready,
        output data_d, bin_idx, acc_clear, acc_en, dump, out_valid
    );

    modport master (
        output fft_ready, in_data, out_ready,
        input  data_d, bin_idx, acc_clear, acc_en, dump, out_valid
    );
endinterface

// File: rtl/bin_avg_sequencer.sv
// Control sequencer for the N-bin averaging datapath (FFT stream -> packetizer).
// Optional macro BIN_SEQ_HOLD_TIMEOUT_EN adds a HOLD timeout, its counter and the timeout port.
module bin_avg_sequencer #(
    parameter int unsigned BINS   = 4,
    parameter int unsigned N      = 16,
    parameter int unsigned AVG_W  = 8,
    parameter int unsigned DROP_W = 16
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    ,
    parameter int unsigned HOLD_TIMEOUT = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 arest_n,
    input  logic                 enable,
    input  logic [AVG_W-1:0]     n_avgs_in,
    bin_avg_sequencer_if.slave   bus,
    output logic                 busy,
    output logic                 overrun,
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic [DROP_W-1:0]    drop_cnt
);
    localparam int unsigned BIN_W = $clog2(BINS);
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(HOLD_TIMEOUT + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACCUM = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bcnt_q, bcnt_d;
    logic [AVG_W-1:0]   fcnt_q, fcnt_d;
    logic [AVG_W-1:0]   n_lat_q, n_lat_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [N-1:0]       data_q;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               clr_q, clr_d;
    logic               en_q, en_d;
    logic               dump_q, dump_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    logic [TMO_W-1:0]   tcnt_q, tcnt_d;
    logic               tmo_q, tmo_d;
`endif

    logic [AVG_W-1:0]   n_req_c;
    logic               last_bin_c;
    logic               last_frame_c;
    logic [1:0]         drop_inc_c;
    logic [DROP_W:0]    drop_sum_c;

    // A request of zero frames behaves as a single-frame average.
    assign n_req_c      = (n_avgs_in == '0) ? AVG_W'(1) : n_avgs_in;
    assign last_bin_c   = (bcnt_q == BIN_W'(BINS - 1));
    assign last_frame_c = (fcnt_q == n_lat_q - AVG_W'(1));

    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
            n_lat_q <= AVG_W'(1);
            drop_q  <= '0;
            data_q  <= '0;
            bin_q   <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            dump_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
            n_lat_q <= n_lat_d;
            drop_q  <= drop_d;
            data_q  <= bus.in_data;
            bin_q   <= bin_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            dump_q  <= dump_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next state plus the strobes for the sample currently on in_data.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        fcnt_d     = fcnt_q;
        n_lat_d    = n_lat_q;
        bin_d      = '0;
        clr_d      = 1'b0;
        en_d       = 1'b0;
        dump_d     = 1'b0;
        valid_d    = 1'b0;
        ovr_d      = 1'b0;
        drop_inc_c = 2'd0;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
        tcnt_d     = '0;
        tmo_d      = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    n_lat_d = n_req_c;
                    fcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if ((fcnt_q == '0) && !enable) begin
                    state_d = S_IDLE;
                end else if (bus.fft_ready) begin
                    en_d    = 1'b1;
                    clr_d   = (fcnt_q == '0);
                    bcnt_d  = BIN_W'(1);
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                en_d = 1'b1;
                if (bus.fft_ready) begin
                    // Early frame start: abandon the partial average and restart on this sample.
                    ovr_d  = 1'b1;
                    clr_d  = 1'b1;
                    fcnt_d = '0;
                    bcnt_d = BIN_W'(1);
                end else begin
                    bin_d = bcnt_q;
                    clr_d = (fcnt_q == '0);
                    if (last_bin_c) begin
                        bcnt_d = '0;
                        if (last_frame_c) begin
                            dump_d  = 1'b1;
                            fcnt_d  = '0;
                            n_lat_d = n_req_c;
                            state_d = S_HOLD;
                        end else begin
                            fcnt_d  = fcnt_q + AVG_W'(1);
                            state_d = S_WAIT;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BIN_W'(1);
                    end
                end
            end

            S_HOLD: begin
                drop_inc_c = {1'b0, bus.fft_ready};
                if (valid_q && bus.out_ready) begin
                    state_d = enable ? S_WAIT : S_IDLE;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
                end else if (valid_q && (tcnt_q == TMO_W'(HOLD_TIMEOUT - 1))) begin
                    tmo_d      = 1'b1;
                    drop_inc_c = drop_inc_c + 2'd1;
                    state_d    = S_WAIT;
`endif
                end else begin
                    valid_d = 1'b1;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
                    if (valid_q) begin
                        tcnt_d = tcnt_q + TMO_W'(1);
                    end
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Saturating drop counter.
    always_comb begin
        drop_sum_c = {1'b0, drop_q} + (DROP_W + 1)'(drop_inc_c);
        drop_d     = drop_sum_c[DROP_W] ? {DROP_W{1'b1}} : drop_sum_c[DROP_W-1:0];
    end

    assign bus.data_d    = data_q;
    assign bus.bin_idx   = bin_q;
    assign bus.acc_clear = clr_q;
    assign bus.acc_en    = en_q;
    assign bus.dump      = dump_q;
    assign bus.out_valid = valid_q;
    assign busy          = busy_q;
    assign overrun       = ovr_q;
    assign drop_cnt      = drop_q;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    assign timeout       = tmo_q;
`endif

endmodule

// File: tb/tb_bin_avg_sequencer.sv
// Self-checking bench for bin_avg_sequencer: frame-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bin_avg_sequencer;
    localparam int unsigned BINS   = 4;
    localparam int unsigned N      = 16;
    localparam int unsigned AVG_W  = 8;
    localparam int unsigned DROP_W = 16;
    localparam int          DROP_MAX = (2 ** DROP_W) - 1;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    localparam int unsigned HT = 8;
`endif

    logic             clk = 1'b0;
    logic             arest_n;
    logic             enable;
    logic [AVG_W-1:0] n_avgs;
    logic             busy;
    logic             overrun;
    logic [DROP_W-1:0] drop_cnt;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
    logic             timeout;
`endif

    bin_avg_sequencer_if #(.N(N), .BINS(BINS)) bus ();

    bin_avg_sequencer #(
        .BINS(BINS), .N(N), .AVG_W(AVG_W), .DROP_W(DROP_W)
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
        , .HOLD_TIMEOUT(HT)
`endif
    ) dut (
        .clk      (clk),
        .arest_n  (arest_n),
        .enable   (enable),
        .n_avgs_in(n_avgs),
        .bus      (bus.slave),
        .busy     (busy),
        .overrun  (overrun),
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
        .timeout  (timeout),
`endif
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame / average level) ----------------
    bit         m_run = 0, m_hold = 0, m_vis = 0, m_inframe = 0;
    int         m_bin = 0, m_frame = 0, m_nlat = 1, m_drops = 0, m_tcnt = 0;
    logic [N-1:0] e_data = '0;
    int         e_bin = 0;
    bit         e_clr = 0, e_en = 0, e_dump = 0, e_valid = 0, e_busy = 0, e_ovr = 0, e_tmo = 0;

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_vis = 0; m_inframe = 0;
        m_bin = 0; m_frame = 0; m_nlat = 1; m_drops = 0; m_tcnt = 0;
        e_data = '0; e_bin = 0; e_clr = 0; e_en = 0; e_dump = 0;
        e_valid = 0; e_busy = 0; e_ovr = 0; e_tmo = 0;
    endtask

    task automatic start_frame();
        e_en = 1; e_bin = 0; e_clr = (m_frame == 0);
        m_bin = 1; m_inframe = 1;
    endtask

    task automatic model_step();
        e_data = bus.in_data;
        e_en = 0; e_clr = 0; e_dump = 0; e_ovr = 0; e_tmo = 0; e_bin = 0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1; m_frame = 0; m_inframe = 0;
                m_nlat = (n_avgs == 0) ? 1 : int'(n_avgs);
            end
        end else if (m_hold) begin
            if (bus.fft_ready) m_drops++;
            if (m_vis && bus.out_ready) begin
                m_hold = 0; m_vis = 0; m_run = enable;
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
            end else if (m_vis && m_tcnt == int'(HT) - 1) begin
                m_hold = 0; m_vis = 0; m_drops++; e_tmo = 1;
`endif
            end else begin
                m_tcnt = m_vis ? m_tcnt + 1 : 0;
                m_vis = 1;
            end
        end else if (!m_inframe) begin
            if (m_frame == 0 && !enable) m_run = 0;
            else if (bus.fft_ready) start_frame();
        end else if (bus.fft_ready) begin
            e_ovr = 1; m_frame = 0;
            start_frame();
        end else begin
            e_en = 1; e_bin = m_bin; e_clr = (m_frame == 0);
            if (m_bin == int'(BINS) - 1) begin
                m_inframe = 0;
                if (m_frame == m_nlat - 1) begin
                    e_dump = 1; m_frame = 0; m_hold = 1; m_vis = 0;
                    m_nlat = (n_avgs == 0) ? 1 : int'(n_avgs);
                end else begin
                    m_frame++;
                end
            end else begin
                m_bin++;
            end
        end
        e_valid = m_hold && m_vis;
        e_busy  = m_run;
    endtask

    always @(posedge clk or negedge arest_n) begin
        if (!arest_n) model_reset();
        else          model_step();
    end

    // ---------------- per-cycle compare and event counters ----------------
    int c_clr = 0, c_en = 0, c_dump = 0, c_ovr = 0, c_vld = 0;

    task automatic compare_cycle();
        chk("data_d",    32'(bus.data_d),    32'(e_data));
        chk("acc_en",    32'(bus.acc_en),    32'(e_en));
        chk("acc_clear", 32'(bus.acc_clear), 32'(e_clr));
        chk("dump",      32'(bus.dump),      32'(e_dump));
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("busy",      32'(busy),          32'(e_busy));
        chk("overrun",   32'(overrun),       32'(e_ovr));
        chk("drop_cnt",  32'(drop_cnt),      32'((m_drops > DROP_MAX) ? DROP_MAX : m_drops));
        if (e_en) chk("bin_idx", 32'(bus.bin_idx), 32'(e_bin));
`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
        chk("timeout",   32'(timeout),       32'(e_tmo));
`endif
        if (arest_n) begin
            c_clr  += int'(bus.acc_clear);
            c_en   += int'(bus.acc_en);
            c_dump += int'(bus.dump);
            c_ovr  += int'(overrun);
            c_vld  += int'(bus.out_valid);
        end
    endtask

    always @(negedge clk) compare_cycle();

    // ---------------- stimulus ----------------
    logic [N-1:0] tbl [0:23];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one full frame starting at the current negedge; optionally pin strobes.
    task automatic frame(input int base, input int gap, input bit pin, input bit pin_clr);
        for (int b = 0; b < int'(BINS); b++) begin
            bus.fft_ready = (b == 0);
            bus.in_data   = tbl[(base + b) % 24];
            @(negedge clk);
            if (pin) begin
                chk("pin_data",  32'(bus.data_d),    32'(tbl[(base + b) % 24]));
                chk("pin_bin",   32'(bus.bin_idx),   32'(b));
                chk("pin_en",    32'(bus.acc_en),    32'd1);
                chk("pin_clr",   32'(bus.acc_clear), 32'(pin_clr));
                chk("pin_dump",  32'(bus.dump),      32'(b == int'(BINS) - 1));
            end
        end
        bus.fft_ready = 1'b0;
        bus.in_data   = N'($urandom);
        step(gap);
    endtask

    task automatic restart(input int n);
        enable = 1'b0;
        step(2);
        chk("restart_idle", 32'(busy), 32'd0);
        n_avgs = AVG_W'(n);
        enable = 1'b1;
        step(2);
    endtask

    int s_clr, s_en, s_dump, s_ovr, s_vld, s_drop;
    logic [5:0] dmask, cmask;
    int k;

    initial begin
        tbl[0]  = 16'h5af7; tbl[1]  = 16'h9a7b; tbl[2]  = 16'h2392; tbl[3]  = 16'hdc44;
        tbl[4]  = 16'h0001; tbl[5]  = 16'h8000; tbl[6]  = 16'hffff; tbl[7]  = 16'h1234;
        tbl[8]  = 16'h3c3c; tbl[9]  = 16'hc3c3; tbl[10] = 16'h00ff; tbl[11] = 16'hff00;
        tbl[12] = 16'h7e57; tbl[13] = 16'h4242; tbl[14] = 16'hbeef; tbl[15] = 16'hcafe;
        tbl[16] = 16'h0f0f; tbl[17] = 16'hf0f0; tbl[18] = 16'h1111; tbl[19] = 16'h2222;
        tbl[20] = 16'h3333; tbl[21] = 16'h4444; tbl[22] = 16'h5555; tbl[23] = 16'h6666;

        arest_n = 1'b0; enable = 1'b1; n_avgs = AVG_W'(1);
        bus.fft_ready = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        step(3);
        chk("reset_busy",  32'(busy),          32'd0);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_drop",  32'(drop_cnt),      32'd0);
        arest_n = 1'b1;
        step(2);

        // 1: single-frame averages, each frame clears and dumps
        s_clr = c_clr; s_en = c_en; s_dump = c_dump; s_vld = c_vld;
        frame(0, 4, 1'b1, 1'b1);
        frame(4, 4, 1'b0, 1'b0);
        frame(8, 4, 1'b0, 1'b0);
        frame(12, 4, 1'b0, 1'b0);
        chk("t1_clr_cycles", 32'(c_clr - s_clr), 32'd16);
        chk("t1_en_cycles",  32'(c_en - s_en),   32'd16);
        chk("t1_dumps",      32'(c_dump - s_dump), 32'd4);
        chk("t1_valid",      32'(c_vld - s_vld), 32'd4);

        // 2: three-frame averages, n_avgs changes mid-average ignored
        restart(3);
        dmask = '0; cmask = '0;
        for (int f = 0; f < 6; f++) begin
            if (f == 1) n_avgs = AVG_W'(2);
            if (f == 2) n_avgs = AVG_W'(3);
            s_clr = c_clr; s_dump = c_dump;
            frame(f * 4, 4, 1'b0, 1'b0);
            dmask[f] = (c_dump != s_dump);
            cmask[f] = (c_clr != s_clr);
        end
        chk("t2_dump_frames",  32'(dmask), 32'h24);
        chk("t2_clear_frames", 32'(cmask), 32'h09);

        // 3: result held, three frames dropped
        restart(1);
        bus.out_ready = 1'b0;
        frame(16, 4, 1'b0, 1'b0);
        s_en = c_en;
        frame(0, 4, 1'b0, 1'b0);
        frame(4, 4, 1'b0, 1'b0);
        frame(8, 4, 1'b0, 1'b0);
        chk("t3_drop_cnt",  32'(drop_cnt),      32'd3);
        chk("t3_no_strobe", 32'(c_en - s_en),   32'd0);
        chk("t3_held",      32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(3);
        chk("t3_released",  32'(bus.out_valid), 32'd0);
        chk("t3_busy",      32'(busy),          32'd1);
        frame(20, 4, 1'b1, 1'b1);

        // 4: early fft_ready at bin 2 restarts the average
        restart(2);
        s_dump = c_dump; s_ovr = c_ovr;
        bus.fft_ready = 1'b1; bus.in_data = tbl[3]; step(1);
        bus.fft_ready = 1'b0; bus.in_data = tbl[5]; step(1);
        bus.fft_ready = 1'b1; bus.in_data = tbl[7]; step(1);
        chk("t4_overrun",  32'(overrun),       32'd1);
        chk("t4_clr",      32'(bus.acc_clear), 32'd1);
        chk("t4_bin0",     32'(bus.bin_idx),   32'd0);
        chk("t4_data",     32'(bus.data_d),    32'(tbl[7]));
        for (int b = 1; b < int'(BINS); b++) begin
            bus.fft_ready = 1'b0; bus.in_data = tbl[8 + b]; step(1);
        end
        bus.in_data = '0;
        step(4);
        chk("t4_no_dump",  32'(c_dump - s_dump), 32'd0);
        frame(12, 4, 1'b0, 1'b0);
        chk("t4_one_dump", 32'(c_dump - s_dump), 32'd1);
        chk("t4_ovr_once", 32'(c_ovr - s_ovr),   32'd1);

        // 5: asynchronous reset mid-frame, then n_avgs=0 acts as 1
        s_dump = c_dump;
        bus.fft_ready = 1'b1; bus.in_data = tbl[0]; step(1);
        bus.fft_ready = 1'b0; bus.in_data = tbl[1];
        chk("t5_pre_en", 32'(bus.acc_en), 32'd1);
        #2 arest_n = 1'b0;
        #1;
        chk("t5_rst_en",    32'(bus.acc_en),    32'd0);
        chk("t5_rst_clr",   32'(bus.acc_clear), 32'd0);
        chk("t5_rst_dump",  32'(bus.dump),      32'd0);
        chk("t5_rst_busy",  32'(busy),          32'd0);
        chk("t5_rst_data",  32'(bus.data_d),    32'd0);
        chk("t5_rst_drop",  32'(drop_cnt),      32'd0);
        n_avgs = '0; enable = 1'b1;
        step(2);
        chk("t5_no_dump", 32'(c_dump - s_dump), 32'd0);
        arest_n = 1'b1;
        step(2);
        s_clr = c_clr;
        frame(4, 4, 1'b1, 1'b1);
        chk("t5_n0_dump", 32'(c_dump - s_dump), 32'd1);
        chk("t5_n0_clr",  32'(c_clr - s_clr),   32'd4);

`ifdef BIN_SEQ_HOLD_TIMEOUT_EN
        // 6: held result discarded after HT cycles without out_ready
        bus.out_ready = 1'b0;
        frame(8, 0, 1'b0, 1'b0);
        k = 0;
        while (!bus.out_valid && k < 20) begin step(1); k++; end
        chk("t6_valid_rise", 32'(bus.out_valid), 32'd1);
        k = 0;
        while (!timeout && k < 30) begin step(1); k++; end
        chk("t6_tmo_delay", 32'(k),             32'(HT));
        chk("t6_drop",      32'(drop_cnt),      32'd1);
        chk("t6_valid_low", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("t6_busy",      32'(busy),          32'd1);
        chk("t6_tmo_pulse", 32'(timeout),       32'd0);
        bus.out_ready = 1'b1;
        s_clr = c_clr;
        frame(12, 4, 1'b1, 1'b1);
        chk("t6_accepts", 32'(c_clr - s_clr), 32'd4);
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
